alu_op_sequencer: RTL and testbench

Sequencing front-end for the combinational ALU: accepts one instruction (opcode plus operands) per valid/ready handshake and drives the ALU's one-hot control lines and operand buses for exactly one cycle. It captures the ALU result and overflow into an accumulator and returns them over a second valid/ready handshake. It sits between the instruction source (decoder/testbench) and the ALU, and is the only block permitted to drive ALU control lines.

---
 rtl/alu_op_sequencer.sv | 87 ++++++++
 tb/tb_alu_op_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one instruction at a time to the combinational ALU.
// It captures the ALU result into the accumulator and returns it over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [2:0]             opcode,
  input  logic                   use_acc,
  input  logic [DATA_WIDTH-1:0]  operand_a,
  input  logic [DATA_WIDTH-1:0]  operand_b,
  output logic                   alu_add,
  output logic                   alu_sub,
  output logic                   alu_and,
  output logic                   alu_or,
  output logic                   alu_xor,
  output logic                   alu_inv,
  output logic                   alu_clr,
  output logic [DATA_WIDTH-1:0]  alu_in1,
  output logic [DATA_WIDTH-1:0]  alu_in2,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic                   alu_overflow,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   result_overflow,
  output logic                   result_err,
  output logic [DATA_WIDTH-1:0]  acc,
  output logic                   sticky_ovf,
  output logic [COUNT_WIDTH-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] op_q;
  logic issue, illegal, clr;
  assign illegal = op_q == 3'b111;
  assign clr     = op_q == 3'b110;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx     = state;
    state_nx     = (state == IDLE && instr_valid) ? ISSUE :
                   (state == ISSUE) ? RESP :
                   (state == RESP && result_ready) ? IDLE : state;
    issue        = state == ISSUE;
    instr_ready  = state == IDLE;
    result_valid = state == RESP;
    alu_add      = issue && op_q == 3'd0;
    alu_sub      = issue && op_q == 3'd1;
    alu_and      = issue && op_q == 3'd2;
    alu_or       = issue && op_q == 3'd3;
    alu_xor      = issue && op_q == 3'd4;
    alu_inv      = issue && op_q == 3'd5;
    alu_clr      = issue && op_q == 3'd6;
  end
  // Illegal and CLR ops report a zero result regardless of what the ALU drives.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q            <= '0;
      alu_in1         <= '0;
      alu_in2         <= '0;
      result          <= '0;
      result_overflow <= 1'b0;
      result_err      <= 1'b0;
      acc             <= '0;
      sticky_ovf      <= 1'b0;
      op_count        <= '0;
    end else begin
      if (state == IDLE && instr_valid) begin
        op_q    <= opcode;
        alu_in1 <= use_acc ? acc : operand_a;
        alu_in2 <= operand_b;
      end
      if (issue) begin
        result          <= (illegal || clr) ? '0 : alu_out;
        result_overflow <= (illegal || clr) ? 1'b0 : alu_overflow;
        result_err      <= illegal;
        acc             <= illegal ? acc : clr ? '0 : alu_out;
        sticky_ovf      <= illegal ? sticky_ovf : clr ? 1'b0 : sticky_ovf | alu_overflow;
      end
      if (state == RESP && result_ready) op_count <= op_count + COUNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed ops against a behavioural ALU, with a scoreboard queue
// popped by a monitor on each result handshake.
module tb_alu_op_sequencer;
  logic clk = 0, rst_n = 0;
  logic instr_valid = 0, instr_ready, use_acc = 0, result_ready = 1;
  logic [2:0] opcode = 0;
  logic [7:0] operand_a = 0, operand_b = 0, alu_in1, alu_in2, alu_out, result, acc;
  logic alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr, alu_overflow;
  logic result_valid, result_overflow, result_err, sticky_ovf;
  logic [15:0] op_count;
  logic [6:0] ctl;
  int total = 0, bad = 0;

  typedef struct {
    logic [7:0] res;
    logic ovf, err;
    logic [7:0] acc;
    logic sticky;
    logic [6:0] ctl;
  } exp_t;
  exp_t sb[$];

  alu_op_sequencer #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .use_acc(use_acc), .operand_a(operand_a), .operand_b(operand_b),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_and(alu_and), .alu_or(alu_or),
    .alu_xor(alu_xor), .alu_inv(alu_inv), .alu_clr(alu_clr),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out), .alu_overflow(alu_overflow),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .result_overflow(result_overflow), .result_err(result_err), .acc(acc),
    .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;
  assign ctl = {alu_clr, alu_inv, alu_xor, alu_or, alu_and, alu_sub, alu_add};

  // Behavioural ALU: unsigned carry/borrow as overflow, logic ops on the low nibble.
  always_comb begin
    {alu_overflow, alu_out} = 9'h0;
    if (alu_add) {alu_overflow, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
    else if (alu_sub) {alu_overflow, alu_out} = {1'b0, alu_in1} - {1'b0, alu_in2};
    else if (alu_and) alu_out = {4'h0, alu_in1[3:0] & alu_in2[3:0]};
    else if (alu_or) alu_out = {4'h0, alu_in1[3:0] | alu_in2[3:0]};
    else if (alu_xor) alu_out = {4'h0, alu_in1[3:0] ^ alu_in2[3:0]};
    else if (alu_inv) alu_out = {4'h0, ~alu_in1[3:0]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] ctl_seen = 0;
  int ctl_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ctl_seen = 0;
      ctl_cnt = 0;
    end else begin
      if (|ctl) begin
        ctl_seen = ctl_seen | ctl;
        ctl_cnt++;
      end
      if (result_valid && result_ready) begin
        if (sb.size() == 0) check("sb_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_result", result, e.res);
          check("sb_ovf", result_overflow, e.ovf);
          check("sb_err", result_err, e.err);
          check("sb_acc", acc, e.acc);
          check("sb_sticky", sticky_ovf, e.sticky);
          check("sb_ctl", ctl_seen, e.ctl);
          check("sb_ctl_cycles", ctl_cnt, (e.ctl != 0) ? 1 : 0);
        end
        ctl_seen = 0;
        ctl_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) check("idle_timeout", 0, 1);
  endtask

  // Called one step after a rising edge with the sequencer in IDLE.
  task automatic do_op(input logic [2:0] op, input logic ua, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_in1, input logic [7:0] eres, input logic eovf,
                       input logic eerr, input logic [7:0] eacc, input logic esticky,
                       input logic [6:0] ectl, input int stall);
    exp_t e;
    e.res = eres; e.ovf = eovf; e.err = eerr; e.acc = eacc; e.sticky = esticky; e.ctl = ectl;
    sb.push_back(e);
    result_ready = (stall == 0);
    instr_valid = 1; opcode = op; use_acc = ua; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    instr_valid = 0;
    check("issue_ctl", ctl, ectl);
    check("issue_in1", alu_in1, exp_in1);
    check("issue_in2", alu_in2, b);
    check("issue_not_ready", instr_ready, 0);
    @(posedge clk); #1;
    check("resp_ctl_off", ctl, 0);
    check("resp_valid", result_valid, 1);
    for (int i = 0; i < stall; i++) begin
      instr_valid = 1; opcode = 3'd0; operand_a = 8'h77; operand_b = 8'h11; use_acc = 0;
      check("stall_valid", result_valid, 1);
      check("stall_ready", instr_ready, 0);
      check("stall_result", result, eres);
      @(posedge clk); #1;
    end
    instr_valid = 0;
    result_ready = 1;
    wait_idle();
  endtask

  initial begin
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_ctl", ctl, 0);
    check("rst_in1", alu_in1, 0);
    check("rst_in2", alu_in2, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", {result_err, result_overflow, result}, 0);
    check("rst_acc", acc, 0);
    check("rst_sticky", sticky_ovf, 0);
    check("rst_count", op_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    //     op    ua  a      b      in1    res    ovf err acc    stk ctl     stall
    do_op(3'd0, 0, 8'h05, 8'h03, 8'h05, 8'h08, 0, 0, 8'h08, 0, 7'h01, 0);
    check("count_1", op_count, 1);
    do_op(3'd0, 0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1, 0, 8'h00, 1, 7'h01, 0);
    do_op(3'd6, 0, 8'h12, 8'h34, 8'h12, 8'h00, 0, 0, 8'h00, 0, 7'h40, 0);
    do_op(3'd0, 0, 8'h10, 8'h20, 8'h10, 8'h30, 0, 0, 8'h30, 0, 7'h01, 0);
    do_op(3'd1, 1, 8'h99, 8'h05, 8'h30, 8'h2B, 0, 0, 8'h2B, 0, 7'h02, 0);
    do_op(3'd2, 0, 8'hAC, 8'h6F, 8'hAC, 8'h0C, 0, 0, 8'h0C, 0, 7'h04, 0);
    do_op(3'd7, 0, 8'h11, 8'h22, 8'h11, 8'h00, 0, 1, 8'h0C, 0, 7'h00, 0);
    check("count_illegal", op_count, 7);
    do_op(3'd4, 0, 8'h0A, 8'h03, 8'h0A, 8'h09, 0, 0, 8'h09, 0, 7'h10, 5);
    check("count_stall", op_count, 8);
    do_op(3'd5, 0, 8'h35, 8'h00, 8'h35, 8'h0A, 0, 0, 8'h0A, 0, 7'h20, 0);
    do_op(3'd1, 0, 8'h03, 8'h05, 8'h03, 8'hFE, 1, 0, 8'hFE, 1, 7'h02, 0);
    do_op(3'd3, 0, 8'h50, 8'h0C, 8'h50, 8'h0C, 0, 0, 8'h0C, 1, 7'h08, 0);
    check("count_pre_rst", op_count, 11);
    // Reset while the ADD is in ISSUE: everything returns to reset values at once.
    instr_valid = 1; opcode = 3'd0; use_acc = 0; operand_a = 8'h01; operand_b = 8'h01;
    @(posedge clk); #1;
    instr_valid = 0;
    check("mid_issue_add", alu_add, 1);
    #1 rst_n = 0;
    #1;
    check("arst_ctl", ctl, 0);
    check("arst_in", {alu_in1, alu_in2}, 0);
    check("arst_valid", result_valid, 0);
    check("arst_ready", instr_ready, 1);
    check("arst_result", {result_err, result_overflow, result}, 0);
    check("arst_acc", acc, 0);
    check("arst_sticky", sticky_ovf, 0);
    check("arst_count", op_count, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    do_op(3'd0, 0, 8'h01, 8'h01, 8'h01, 8'h02, 0, 0, 8'h02, 0, 7'h01, 0);
    check("count_after_rst", op_count, 1);
    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
